// File: rtl/edge_detect_multi.sv
// Multi-channel valid-qualified edge detector: per-channel INIT/LOW/HIGH FSM,
// selectable edge qualification, registered pulses, saturating counters and sticky flags.
module edge_detect_multi #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [N_CH-1:0]         in_data,
   input  logic [1:0]              mode,
   input  logic [N_CH-1:0]         clr,
   output logic [N_CH-1:0]         pulse,
   output logic [N_CH-1:0]         sticky,
   output logic [N_CH*CNT_W-1:0]   edge_cnt,
   output logic                    any_edge
);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [N_CH-1:0] qual_vec;
   logic            any_edge_q;

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         state_t           state_q, state_d;
         logic             rise, fall, qual;
         logic             pulse_q;
         logic             sticky_q, sticky_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;

         always_comb begin
            state_d = state_q;
            rise    = 1'b0;
            fall    = 1'b0;
            if (in_valid) begin
               case (state_q)
                  ST_INIT: state_d = in_data[gi] ? ST_HIGH : ST_LOW;
                  ST_LOW: begin
                     if (in_data[gi]) begin
                        rise    = 1'b1;
                        state_d = ST_HIGH;
                     end
                  end
                  ST_HIGH: begin
                     if (!in_data[gi]) begin
                        fall    = 1'b1;
                        state_d = ST_LOW;
                     end
                  end
                  default: state_d = ST_INIT;
               endcase
            end

            // Tracking above runs in every mode; mode only gates what counts as an edge.
            case (mode)
               2'b00:   qual = rise | fall;
               2'b01:   qual = rise;
               2'b10:   qual = fall;
               default: qual = 1'b0;
            endcase

            sticky_d = sticky_q;
            cnt_d    = cnt_q;
            if (qual) begin
               sticky_d = 1'b1;
               if (clr[gi])
                  cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
               else if (cnt_q != CNT_MAX)
                  cnt_d = cnt_q + 1'b1;
            end else if (clr[gi]) begin
               sticky_d = 1'b0;
               cnt_d    = '0;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               state_q  <= ST_INIT;
               pulse_q  <= 1'b0;
               sticky_q <= 1'b0;
               cnt_q    <= '0;
            end else begin
               state_q  <= state_d;
               pulse_q  <= qual;
               sticky_q <= sticky_d;
               cnt_q    <= cnt_d;
            end
         end

         assign qual_vec[gi]                    = qual;
         assign pulse[gi]                       = pulse_q;
         assign sticky[gi]                      = sticky_q;
         assign edge_cnt[gi*CNT_W +: CNT_W]     = cnt_q;
      end
   endgenerate

   // Reduced from the same-cycle qualifiers so it lines up with pulse.
   always_ff @(posedge clk) begin
      if (rst)
         any_edge_q <= 1'b0;
      else
         any_edge_q <= |qual_vec;
   end

   assign any_edge = any_edge_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi (N_CH=4, CNT_W=2 so saturation is reachable).
module tb_edge_detect_multi;

   localparam int N_CH  = 4;
   localparam int CNT_W = 2;

   logic                  clk;
   logic                  rst;
   logic                  in_valid;
   logic [N_CH-1:0]       in_data;
   logic [1:0]            mode;
   logic [N_CH-1:0]       clr;
   logic [N_CH-1:0]       pulse;
   logic [N_CH-1:0]       sticky;
   logic [N_CH*CNT_W-1:0] edge_cnt;
   logic                  any_edge;

   int vec_cnt = 0;
   int err_cnt = 0;

   edge_detect_multi #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .mode     (mode),
      .clr      (clr),
      .pulse    (pulse),
      .sticky   (sticky),
      .edge_cnt (edge_cnt),
      .any_edge (any_edge)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one sample, then land 1 time unit past the edge that captured it.
   task automatic apply(input logic v, input logic [3:0] d, input logic [1:0] m, input logic [3:0] c);
      in_valid = v;
      in_data  = d;
      mode     = m;
      clr      = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply(1'b0, 4'h0, 2'b00, 4'h0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      apply(1'b1, 4'hF, 2'b00, 4'hF);
      apply(1'b1, 4'h0, 2'b00, 4'h0);
      rst = 1'b0;
      vec_cnt++;
      if (pulse !== 4'h0 || any_edge !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_pulse got pulse=%b any=%b want 0000/0", pulse, any_edge);
      end
      vec_cnt++;
      if (sticky !== 4'h0 || edge_cnt !== 8'h00) begin
         err_cnt++;
         $display("FAIL reset_state got sticky=%b cnt=%h want 0000/00", sticky, edge_cnt);
      end
   endtask

   task automatic test_both_edges();
      logic [3:0] d   [5] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h1};
      logic [3:0] exp [5] = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         apply(1'b1, d[i], 2'b00, 4'h0);
         vec_cnt++;
         if (pulse !== exp[i] || any_edge !== exp[i][0]) begin
            err_cnt++;
            $display("FAIL both_pulse[%0d] got pulse=%b any=%b want %b/%b", i, pulse, any_edge, exp[i], exp[i][0]);
         end
      end
      vec_cnt++;
      if (edge_cnt !== 8'h03 || sticky !== 4'h1) begin
         err_cnt++;
         $display("FAIL both_count got cnt=%h sticky=%b want 03/0001", edge_cnt, sticky);
      end
   endtask

   task automatic test_rise_fall_only();
      logic [3:0] d    [4] = '{4'h2, 4'h0, 4'h2, 4'h0};
      logic [3:0] expr [4] = '{4'h0, 4'h0, 4'h2, 4'h0};
      logic [3:0] expf [4] = '{4'h0, 4'h2, 4'h0, 4'h2};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, d[i], 2'b01, 4'h0);
         vec_cnt++;
         if (pulse !== expr[i]) begin
            err_cnt++;
            $display("FAIL rise_pulse[%0d] got %b want %b", i, pulse, expr[i]);
         end
      end
      vec_cnt++;
      if (edge_cnt !== 8'h04) begin
         err_cnt++;
         $display("FAIL rise_count got %h want 04", edge_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, d[i], 2'b10, 4'h0);
         vec_cnt++;
         if (pulse !== expf[i]) begin
            err_cnt++;
            $display("FAIL fall_pulse[%0d] got %b want %b", i, pulse, expf[i]);
         end
      end
      vec_cnt++;
      if (edge_cnt !== 8'h0C || sticky !== 4'h2) begin
         err_cnt++;
         $display("FAIL fall_count got cnt=%h sticky=%b want 0C/0010", edge_cnt, sticky);
      end
   endtask

   task automatic test_valid_gap();
      logic       v   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [3:0] d   [5] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4};
      logic [3:0] exp [5] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h0};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         apply(v[i], d[i], 2'b00, 4'h0);
         vec_cnt++;
         if (pulse !== exp[i] || any_edge !== (exp[i] != 4'h0)) begin
            err_cnt++;
            $display("FAIL gap_pulse[%0d] got pulse=%b any=%b want %b", i, pulse, any_edge, exp[i]);
         end
      end
      vec_cnt++;
      if (edge_cnt !== 8'h10) begin
         err_cnt++;
         $display("FAIL gap_count got %h want 10", edge_cnt);
      end
   endtask

   task automatic test_saturate_clear();
      logic [3:0] d   [6] = '{4'h0, 4'h9, 4'h1, 4'h9, 4'h1, 4'h9};
      logic [3:0] exp [6] = '{4'h0, 4'h9, 4'h8, 4'h8, 4'h8, 4'h8};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         apply(1'b1, d[i], 2'b00, 4'h0);
         vec_cnt++;
         if (pulse !== exp[i]) begin
            err_cnt++;
            $display("FAIL sat_pulse[%0d] got %b want %b", i, pulse, exp[i]);
         end
      end
      vec_cnt++;
      if (edge_cnt !== 8'hC1) begin
         err_cnt++;
         $display("FAIL sat_count got %h want C1", edge_cnt);
      end
      apply(1'b0, 4'h9, 2'b00, 4'h8);
      vec_cnt++;
      if (edge_cnt !== 8'h01 || sticky !== 4'h1) begin
         err_cnt++;
         $display("FAIL clr_noedge got cnt=%h sticky=%b want 01/0001", edge_cnt, sticky);
      end
      apply(1'b1, 4'h1, 2'b00, 4'h8);
      vec_cnt++;
      if (edge_cnt !== 8'h41 || sticky !== 4'h9 || pulse !== 4'h8) begin
         err_cnt++;
         $display("FAIL clr_edge got cnt=%h sticky=%b pulse=%b want 41/1001/1000", edge_cnt, sticky, pulse);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      apply(1'b1, 4'h0, 2'b00, 4'h0);
      apply(1'b1, 4'h1, 2'b00, 4'h0);
      vec_cnt++;
      if (sticky !== 4'h1 || pulse !== 4'h1) begin
         err_cnt++;
         $display("FAIL midrst_pre got sticky=%b pulse=%b want 0001/0001", sticky, pulse);
      end
      rst = 1'b1;
      apply(1'b1, 4'h0, 2'b00, 4'h0);
      rst = 1'b0;
      vec_cnt++;
      if (pulse !== 4'h0 || sticky !== 4'h0 || edge_cnt !== 8'h00 || any_edge !== 1'b0) begin
         err_cnt++;
         $display("FAIL midrst_clear got pulse=%b sticky=%b cnt=%h any=%b want all 0", pulse, sticky, edge_cnt, any_edge);
      end
      apply(1'b1, 4'h0, 2'b00, 4'h0);
      vec_cnt++;
      if (pulse !== 4'h0) begin
         err_cnt++;
         $display("FAIL midrst_first got %b want 0000", pulse);
      end
      apply(1'b1, 4'h1, 2'b00, 4'h0);
      vec_cnt++;
      if (pulse !== 4'h1 || edge_cnt !== 8'h01) begin
         err_cnt++;
         $display("FAIL midrst_rise got pulse=%b cnt=%h want 0001/01", pulse, edge_cnt);
      end
   endtask

   task automatic test_mode_disabled();
      logic [3:0] d   [4] = '{4'h0, 4'h1, 4'h1, 4'h0};
      logic [1:0] m   [4] = '{2'b11, 2'b11, 2'b00, 2'b00};
      logic [3:0] exp [4] = '{4'h0, 4'h0, 4'h0, 4'h1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, d[i], m[i], 4'h0);
         vec_cnt++;
         if (pulse !== exp[i]) begin
            err_cnt++;
            $display("FAIL dis_pulse[%0d] got %b want %b", i, pulse, exp[i]);
         end
      end
      vec_cnt++;
      if (edge_cnt !== 8'h01 || sticky !== 4'h1) begin
         err_cnt++;
         $display("FAIL dis_count got cnt=%h sticky=%b want 01/0001", edge_cnt, sticky);
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      mode     = 2'b00;
      clr      = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_both_edges();
      test_rise_fall_only();
      test_valid_gap();
      test_saturate_clear();
      test_mid_reset();
      test_mode_disabled();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Parametrised, multi-channel successor to the single-bit change-detecting Mealy FSM.
- Each of N_CH channels runs its own INIT/LOW/HIGH state machine on a valid-qualified input stream and emits a registered one-cycle pulse on a qualifying edge.
- Edge qualification is selectable: both, rising, falling or disabled.
- Adds per-channel saturating edge counters, sticky flags with per-channel clear, and an OR-reduced summary output for the interrupt/status logic.

Parameters:
N_CH, 4, number of independent channels (>=1)
CNT_W, 8, width of each per-channel edge counter (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  qualifies in_data; channels sample only when 1
in_data  input  N_CH  one input bit per channel
mode  input  2  00 both edges, 01 rising only, 10 falling only, 11 detection disabled
clr  input  N_CH  per-channel clear of sticky flag and counter
pulse  output  N_CH  registered one-cycle edge pulse per channel
sticky  output  N_CH  per-channel latched "edge seen" flag
edge_cnt  output  N_CH*CNT_W  packed counters; channel i occupies bits [i*CNT_W +: CNT_W]
any_edge  output  1  registered OR of all pulse bits computed from the same sample (same cycle as pulse)

Behaviour:
- Reset (rst=1 at a clk edge): every channel goes to INIT; pulse=0, sticky=0, edge_cnt=0, any_edge=0.
  - Reset mid-operation discards all history.
  - The first valid sample after reset never pulses.
  - rst overrides in_valid and clr.
- Per-channel states: INIT (no history), LOW (last valid sample 0), HIGH (last valid sample 1).
- in_valid=0: state, sticky and edge_cnt hold; pulse and any_edge are 0 next cycle.
- in_valid=1, per channel i, with d=in_data[i]:
  - INIT: next state LOW if d=0, HIGH if d=1; no edge.
  - LOW and d=1: rising edge; next state HIGH.
  - HIGH and d=0: falling edge; next state LOW.
  - LOW and d=0, or HIGH and d=1: no edge; state holds.
- Qualification by mode:
  - 00: both rising and falling edges qualify.
  - 01: rising only.
  - 10: falling only.
  - 11: none qualify.
  - State tracking continues in every mode, including 11, so a mode change never produces a spurious edge.
  - mode is sampled in the same cycle as in_data.
- Latency: a qualifying edge sampled at clk edge k drives pulse[i]=1 during the cycle after edge k, for exactly one cycle.
  - Consecutive alternating valid samples give back-to-back pulses with no gap.
- Counter: increments by 1 on each qualifying edge and saturates at 2^CNT_W-1; it does not wrap.
- Sticky: set on a qualifying edge and held until clr[i] or rst.
- clr[i] on the same cycle as a qualifying edge on channel i: the edge wins, giving sticky=1 and edge_cnt=1.
- clr[i] without an edge: sticky=0 and edge_cnt=0.
- clr has no effect on the FSM state or on pulse.
- Channels are fully independent; a clr on one channel does not affect the others.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset, then valid ch0 samples 0,1,1,0,1 with mode=00 -> pulse[0]=0,1,0,1,1 (each one cycle late); edge_cnt ch0=3; sticky[0]=1; any_edge follows pulse[0].
- mode=01, ch1 samples 1,0,1,0 -> only the 0->1 transition pulses (one pulse); edge_cnt ch1=1. Repeat with mode=10 -> only falling edges pulse.
- in_valid toggled 1,0,0,1 with in_data[2]: 0, 1, 1, 1 -> no pulse during the invalid cycles; a single pulse after the 4th sample (LOW->HIGH); state held across the gap.
- CNT_W=2 with 5 alternating edges on ch3 -> edge_cnt ch3 reaches 3 and stays at 3. clr[3] with no edge -> 0. clr[3] coincident with an edge -> sticky=1, edge_cnt ch3=1.
- rst asserted mid-stream with ch0 in HIGH and sticky set -> all outputs 0. The next valid sample of 0 gives no pulse (INIT->LOW); a following 1 pulses.
- mode=11 while ch0 goes 0->1, then mode=00 with in_data[0]=1 held -> no pulse at any point; a later 1->0 sample pulses.
